// File: rtl/alu_control_def.sv
// Shared ALU control codes and the EX/MEM control bundle.
// Operation classes are contiguous code ranges.
package alu_control_def;

    localparam logic [4:0] ALUCTRL_ADD    = 5'd0;
    localparam logic [4:0] ALUCTRL_SUB    = 5'd1;
    localparam logic [4:0] ALUCTRL_AND    = 5'd2;
    localparam logic [4:0] ALUCTRL_OR     = 5'd3;
    localparam logic [4:0] ALUCTRL_XOR    = 5'd4;
    localparam logic [4:0] ALUCTRL_SLL    = 5'd5;
    localparam logic [4:0] ALUCTRL_SRL    = 5'd6;
    localparam logic [4:0] ALUCTRL_SRA    = 5'd7;
    localparam logic [4:0] ALUCTRL_SLT    = 5'd8;
    localparam logic [4:0] ALUCTRL_SLTU   = 5'd9;
    localparam logic [4:0] ALUCTRL_BEQ    = 5'd10;
    localparam logic [4:0] ALUCTRL_BNE    = 5'd11;
    localparam logic [4:0] ALUCTRL_BLT    = 5'd12;
    localparam logic [4:0] ALUCTRL_BGE    = 5'd13;
    localparam logic [4:0] ALUCTRL_BLTU   = 5'd14;
    localparam logic [4:0] ALUCTRL_BGEU   = 5'd15;
    localparam logic [4:0] ALUCTRL_JAL    = 5'd16;
    localparam logic [4:0] ALUCTRL_JALR   = 5'd17;
    localparam logic [4:0] ALUCTRL_MUL    = 5'd18;
    localparam logic [4:0] ALUCTRL_MULH   = 5'd19;
    localparam logic [4:0] ALUCTRL_MULHSU = 5'd20;
    localparam logic [4:0] ALUCTRL_MULHU  = 5'd21;
    localparam logic [4:0] ALUCTRL_DIV    = 5'd22;
    localparam logic [4:0] ALUCTRL_DIVU   = 5'd23;
    localparam logic [4:0] ALUCTRL_REM    = 5'd24;
    localparam logic [4:0] ALUCTRL_REMU   = 5'd25;

    localparam logic [4:0] ALUCTRL_MD_LO = ALUCTRL_MUL;
    localparam logic [4:0] ALUCTRL_MD_HI = ALUCTRL_REMU;
    localparam logic [4:0] ALUCTRL_BR_LO = ALUCTRL_BEQ;
    localparam logic [4:0] ALUCTRL_BR_HI = ALUCTRL_JALR;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       taken;
        logic [4:0] rd;
    } ex_mem_ctl_t;

endpackage

// File: rtl/ex_mem_reg.sv
// Pipeline register slot: loads a bundle, or a bubble that
// clears every control bit.
module ex_mem_reg
    import alu_control_def::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            bubble,
    input  ex_mem_ctl_t     ctl_d,
    input  logic [XLEN-1:0] result_d,
    input  logic [XLEN-1:0] wdata_d,
    output ex_mem_ctl_t     ctl_q,
    output logic [XLEN-1:0] result_q,
    output logic [XLEN-1:0] wdata_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q    <= '0;
            result_q <= '0;
            wdata_q  <= '0;
        end else if (load) begin
            ctl_q    <= bubble ? '0 : ctl_d;
            result_q <= result_d;
            wdata_q  <= wdata_d;
        end
    end

endmodule

// File: rtl/ex_stage_ctrl.sv
// EX stage control: sequences multi-cycle mult/div, parks a
// finished result in a skid slot while MEM is stalled.
module ex_stage_ctrl
    import alu_control_def::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [CTRL_W-1:0] ex_alu_ctrl,
    input  logic [4:0]        ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic              ex_memwrite,
    input  logic [XLEN-1:0]   ex_wdata,
    input  logic [XLEN-1:0]   alu_result,
    input  logic              alu_is_zero,
    input  logic              alu_ready,
    input  logic              mem_stall,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    output logic              stall_ex,
    output logic              mem_valid,
    output logic              mem_regwrite,
    output logic              mem_memread,
    output logic              mem_memwrite,
    output logic              mem_taken,
    output logic [4:0]        mem_rd,
    output logic [XLEN-1:0]   mem_result,
    output logic [XLEN-1:0]   mem_wdata
);

    typedef enum logic [1:0] {RUN, WAIT_MD, HOLD} state_t;

    state_t state;
    state_t nxt;

    logic md_op;
    logic br_op;
    logic stall;
    logic em_load;
    logic em_bubble;
    logic skid_load;

    ex_mem_ctl_t     ex_ctl;
    ex_mem_ctl_t     em_ctl_d;
    ex_mem_ctl_t     em_ctl;
    ex_mem_ctl_t     skid_ctl;
    logic [XLEN-1:0] em_res_d;
    logic [XLEN-1:0] em_wd_d;
    logic [XLEN-1:0] skid_res;
    logic [XLEN-1:0] skid_wd;

    assign md_op = (int'(ex_alu_ctrl) >= int'(ALUCTRL_MD_LO))
                && (int'(ex_alu_ctrl) <= int'(ALUCTRL_MD_HI));
    assign br_op = (int'(ex_alu_ctrl) >= int'(ALUCTRL_BR_LO))
                && (int'(ex_alu_ctrl) <= int'(ALUCTRL_BR_HI));

    assign ex_ctl = '{
        valid:    ex_valid,
        regwrite: ex_regwrite,
        memread:  ex_memread,
        memwrite: ex_memwrite,
        taken:    ex_valid & alu_is_zero & br_op,
        rd:       ex_rd
    };

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            RUN:     if (ex_valid && md_op) nxt = WAIT_MD;
            WAIT_MD: if (alu_ready) nxt = mem_stall ? HOLD : RUN;
            HOLD:    if (!mem_stall) nxt = RUN;
            default: nxt = RUN;
        endcase
    end

    always_comb begin
        stall     = 1'b0;
        em_load   = 1'b0;
        em_bubble = 1'b0;
        skid_load = 1'b0;
        unique case (state)
            RUN: begin
                if (ex_valid && md_op) begin
                    stall     = 1'b1;
                    em_load   = !mem_stall;
                    em_bubble = 1'b1;
                end else if (mem_stall) begin
                    stall = 1'b1;
                end else begin
                    em_load   = 1'b1;
                    em_bubble = !ex_valid;
                end
            end
            WAIT_MD: begin
                if (!alu_ready) begin
                    stall     = 1'b1;
                    em_load   = !mem_stall;
                    em_bubble = 1'b1;
                end else if (!mem_stall) begin
                    em_load = 1'b1;
                end else begin
                    skid_load = 1'b1;
                end
            end
            HOLD: begin
                stall   = 1'b1;
                em_load = !mem_stall;
            end
            default: ;
        endcase
    end

    // Draining the skid slot takes priority over anything in ID/EX
    assign em_ctl_d = (state == HOLD) ? skid_ctl : ex_ctl;
    assign em_res_d = (state == HOLD) ? skid_res : alu_result;
    assign em_wd_d  = (state == HOLD) ? skid_wd  : ex_wdata;

    ex_mem_reg #(.XLEN(XLEN)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (skid_load),
        .bubble   (1'b0),
        .ctl_d    (ex_ctl),
        .result_d (alu_result),
        .wdata_d  (ex_wdata),
        .ctl_q    (skid_ctl),
        .result_q (skid_res),
        .wdata_q  (skid_wd)
    );

    ex_mem_reg #(.XLEN(XLEN)) u_ex_mem (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (em_load),
        .bubble   (em_bubble),
        .ctl_d    (em_ctl_d),
        .result_d (em_res_d),
        .wdata_d  (em_wd_d),
        .ctl_q    (em_ctl),
        .result_q (mem_result),
        .wdata_q  (mem_wdata)
    );

    assign stall_ex     = stall & rst_n;
    assign alu_ctrl_o   = (ex_valid && state != HOLD)
                        ? ex_alu_ctrl : CTRL_W'(ALUCTRL_ADD);
    assign mem_valid    = em_ctl.valid;
    assign mem_regwrite = em_ctl.regwrite;
    assign mem_memread  = em_ctl.memread;
    assign mem_memwrite = em_ctl.memwrite;
    assign mem_taken    = em_ctl.taken;
    assign mem_rd       = em_ctl.rd;

endmodule
